// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key schedule: expands the cipher key forward to round 10,
// then walks back down to round 0, emitting one round key per accepted transfer.
`ifndef DATA_SIZE
`define DATA_SIZE 128
`endif

module aes_dec_key_sched (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`DATA_SIZE-1:0] key_in,
    input  logic                  key_load,
    output logic                  key_ready,
    output logic [`DATA_SIZE-1:0] rk_out,
    output logic [3:0]            rk_idx,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    // Handshake: a round key moves when rk_valid and rk_ready are both high at a rising
    // edge; rk_out/rk_idx never change while rk_valid=1 and rk_ready=0.
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, OUT = 2'd2} state_t;

    state_t      state;
    logic [7:0]  rcon;
    logic [3:0]  round;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] v0, v1, v2, v3;
    logic [31:0] sub_in, rot, sub_out;
    logic [7:0]  rcon_fwd, rcon_bwd;

    assign w0 = rk_out[127:96];
    assign w1 = rk_out[95:64];
    assign w2 = rk_out[63:32];
    assign w3 = rk_out[31:0];

    // The SubWord path is shared: FWD feeds w3, OUT feeds the recovered previous w3.
    assign v3     = w3 ^ w2;
    assign sub_in = (state == OUT) ? v3 : w3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        bSbox u_sbox (
            .a       (rot[8*i +: 8]),
            .encrypt (1'b1),
            .q       (sub_out[8*i +: 8])
        );
    end

    assign f0 = w0 ^ sub_out ^ {rcon, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign v2 = w2 ^ w1;
    assign v1 = w1 ^ w0;
    assign v0 = w0 ^ sub_out ^ {rcon, 24'h0};

    assign rcon_fwd = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign rcon_bwd = {1'b0, rcon[7:1]} ^ (rcon[0] ? 8'h8d : 8'h00);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rk_out    <= '0;
            rk_idx    <= 4'd0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            rcon      <= 8'h01;
            round     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_load) begin
                        rk_out    <= key_in;
                        rcon      <= 8'h01;
                        round     <= 4'd0;
                        state     <= FWD;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end
                FWD: begin
                    rk_out <= {f0, f1, f2, f3};
                    round  <= round + 4'd1;
                    // Round 10 keeps its rcon (0x36): the backward walk starts from it.
                    if (round == 4'd9) begin
                        state    <= OUT;
                        rk_valid <= 1'b1;
                        rk_idx   <= 4'd10;
                    end else begin
                        rcon <= rcon_fwd;
                    end
                end
                OUT: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_idx != 4'd0) begin
                            rk_out <= {v0, v1, v2, v3};
                            rk_idx <= rk_idx - 4'd1;
                            rcon   <= rcon_bwd;
                        end else begin
                            state     <= IDLE;
                            rk_valid  <= 1'b0;
                            busy      <= 1'b0;
                            key_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// Combinational AES S-box (encrypt=1) or inverse S-box (encrypt=0), built from
// the GF(2^8) multiplicative inverse and the affine transform.
module bSbox (
    input  logic [7:0] a,
    input  logic       encrypt,
    output logic [7:0] q
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ b;
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse for x!=0 and maps 0 to 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] pre;
    logic [7:0] inv;

    assign pre = encrypt ? a : (rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    assign inv = gf_inv(pre);
    assign q   = encrypt ? (inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63)
                         : inv;
endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched: reference key expansion from a brute-force S-box table,
// round keys expected in order 10..0 through an expected queue.
module tb_aes_dec_key_sched;
    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  key_in;
    logic          key_load;
    logic          key_ready;
    logic [W-1:0]  rk_out;
    logic [3:0]    rk_idx;
    logic          rk_valid;
    logic          rk_ready;
    logic          busy;
    logic [1:0]    dbg_state;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    logic [3:0]    exp_idx_q[$];
    logic [W-1:0]  kat[int];
    logic [7:0]    sbox_t[256];

    aes_dec_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int acc, aa, bb;
        acc = 0; aa = x; bb = y;
        while (bb != 0) begin
            if (bb % 2 == 1) acc = acc ^ aa;
            aa = aa * 2;
            if (aa >= 256) aa = aa ^ 'h11b;
            bb = bb / 2;
        end
        return acc[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
            sbox_t[x] = s;
        end
    endtask

    // Standard FIPS-197 expansion into 44 words, queued from round 10 down to round 0.
    task automatic model_push(input logic [W-1:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        int rc;
        rc = 1;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc[7:0], 24'h0};
                rc = rc * 2;
                if (rc >= 256) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 10; r >= 0; r--) begin
            exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
            exp_idx_q.push_back(4'(r));
        end
    endtask

    function automatic logic [W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic async_reset(input string name);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL %s_rst_key_ready: got %0b expected 1", name, key_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_rst_busy: got %0b expected 0", name, busy); end
        n_cmp++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL %s_rst_rk_valid: got %0b expected 0", name, rk_valid); end
        n_cmp++; if (rk_out !== '0) begin n_err++; $display("FAIL %s_rst_rk_out: got %0h expected 0", name, rk_out); end
        n_cmp++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL %s_rst_rk_idx: got %0d expected 0", name, rk_idx); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL %s_rst_state: got %0d expected 0", name, dbg_state); end
        key_in = rand128();
        key_load = 1'b1;
        cyc();
        n_cmp++; if (dbg_state !== 2'd0 || key_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_load_in_rst: got state %0d expected 0", name, dbg_state);
        end
        rst = 1'b0;
        key_load = 1'b0;
        rk_ready = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
    endtask

    // One full load/expand/drain session. pct: rk_ready probability; hold0: initial stall
    // cycles at round 10; inject: pulse key_load with another key while busy;
    // abort_idx>=0: assert reset when that round key is presented.
    task automatic session(input logic [W-1:0] key, input int pct, input int hold0,
                           input bit inject, input int abort_idx, input string name);
        logic [W-1:0] other, snap_rk;
        logic [3:0]   snap_idx;
        logic         snap_v;
        int lat, xfers, budget, held;
        bit done;
        model_push(key);
        other = ~key;
        budget = 0;
        while (!key_ready && budget < 50) begin cyc(); budget++; end
        key_in = key;
        key_load = 1'b1;
        rk_ready = 1'b0;
        cyc();
        key_load = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy_after_load: got %0b expected 1", name, busy); end
        n_cmp++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL %s_key_ready_after_load: got %0b expected 0", name, key_ready); end
        lat = 0;
        while (!rk_valid && lat < 20) begin
            if (inject) begin key_load = 1'($urandom_range(0, 1)); key_in = other; end
            cyc();
            lat++;
        end
        key_load = 1'b0;
        n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end

        xfers = 0; held = 0; budget = 0; done = 1'b0;
        while (!done && budget < 400) begin
            budget++;
            if (abort_idx >= 0 && rk_valid && int'(rk_idx) == abort_idx) begin
                async_reset(name);
                kat.delete();
                return;
            end
            if (held < hold0) begin rk_ready = 1'b0; held++; end
            else rk_ready = ($urandom_range(0, 99) < pct);
            if (inject) begin key_load = 1'($urandom_range(0, 1)); key_in = other; end
            if (rk_valid && rk_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL %s_extra_xfer: got idx %0d expected none", name, rk_idx);
                    done = 1'b1;
                end else begin
                    n_cmp++; if (rk_out !== exp_q[0]) begin n_err++; $display("FAIL %s_rk_out: got %0h expected %0h", name, rk_out, exp_q[0]); end
                    n_cmp++; if (rk_idx !== exp_idx_q[0]) begin n_err++; $display("FAIL %s_rk_idx: got %0d expected %0d", name, rk_idx, exp_idx_q[0]); end
                    if (kat.exists(int'(exp_idx_q[0]))) begin
                        n_cmp++; if (rk_out !== kat[int'(exp_idx_q[0])]) begin
                            n_err++; $display("FAIL %s_kat_idx%0d: got %0h expected %0h", name, exp_idx_q[0], rk_out, kat[int'(exp_idx_q[0])]);
                        end
                    end
                    void'(exp_q.pop_front());
                    void'(exp_idx_q.pop_front());
                    xfers++;
                    // The final-transfer edge must also ignore key_load.
                    if (exp_q.size() == 0) begin
                        if (inject) key_load = 1'b1;
                        done = 1'b1;
                    end
                end
                cyc();
            end else begin
                snap_rk = rk_out; snap_idx = rk_idx; snap_v = rk_valid;
                cyc();
                if (snap_v) begin
                    n_cmp++; if (rk_valid !== 1'b1 || rk_out !== snap_rk || rk_idx !== snap_idx) begin
                        n_err++; $display("FAIL %s_stall_hold: got idx %0d %0h expected idx %0d %0h", name, rk_idx, rk_out, snap_idx, snap_rk);
                    end
                end
            end
        end
        key_load = 1'b0;
        rk_ready = 1'b0;
        n_cmp++; if (xfers !== 11) begin n_err++; $display("FAIL %s_xfer_count: got %0d expected 11", name, xfers); end
        n_cmp++; if (key_ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_err++; $display("FAIL %s_end_idle: got ready %0b busy %0b valid %0b expected 1 0 0", name, key_ready, busy, rk_valid);
        end
        exp_q.delete();
        exp_idx_q.delete();
        kat.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
        #2;
        n_cmp++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %0b expected 1", key_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_rk_valid: got %0b expected 0", rk_valid); end
        n_cmp++; if (rk_out !== '0) begin n_err++; $display("FAIL reset_rk_out: got %0h expected 0", rk_out); end
        n_cmp++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx); end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_fips_vector();
        kat[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        kat[9]  = 128'hac7766f319fadc2128d12941575c006e;
        kat[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        kat[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        session(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 0, 1'b0, -1, "fips");
    endtask

    task automatic test_zero_key();
        kat[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        kat[0]  = 128'h0;
        session(128'h0, 100, 0, 1'b0, -1, "zero");
    endtask

    task automatic test_stalls();
        session(rand128(), 50, 5, 1'b0, -1, "stall");
        session(rand128(), 25, 0, 1'b0, -1, "stall_slow");
    endtask

    task automatic test_ignore_load();
        session(rand128(), 60, 0, 1'b1, -1, "ignore_load");
    endtask

    task automatic test_reset_mid_fwd();
        int budget;
        budget = 0;
        while (!key_ready && budget < 50) begin cyc(); budget++; end
        key_in = rand128();
        key_load = 1'b1;
        cyc();
        key_load = 1'b0;
        repeat (5) cyc();
        n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL mid_fwd_state: got %0d expected 1", dbg_state); end
        async_reset("mid_fwd");
        session(rand128(), 100, 0, 1'b0, -1, "after_fwd_rst");
    endtask

    task automatic test_reset_mid_out();
        session(rand128(), 100, 0, 1'b0, 4, "mid_out");
        session(rand128(), 70, 0, 1'b0, -1, "after_out_rst");
    endtask

    task automatic test_back_to_back();
        session(rand128(), 100, 0, 1'b0, -1, "b2b_first");
        session(rand128(), 100, 0, 1'b0, -1, "b2b_second");
        for (int i = 0; i < 3; i++) session(rand128(), $urandom_range(30, 100), 0, 1'b0, -1, "b2b_rand");
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_zero_key();
        test_stalls();
        test_ignore_load();
        test_reset_mid_fwd();
        test_reset_mid_out();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
